// File: rtl/debounce_pkg.sv
// Shared helpers for the debounce event scheduler.
// Contents:
//   idx_width  - bits needed to index n items (at least 1)
//   cnt_width  - bits needed to hold a counter value 0..max_val
package debounce_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_event_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first requesting index at or after 'pointer', wrapping cyclically.
// Ports:
//   req          in   N        request vector
//   pointer      in   W        highest-priority index this cycle
//   grant_onehot out  N        one-hot grant (zero when nothing requested)
//   grant_idx    out  W        binary index of the grant
//   any          out  1        at least one request present
// The pointer register itself is owned by the instantiating module.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         grant_onehot,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);
  localparam int W  = $clog2(N);
  localparam int W1 = W + 1;

  logic [W:0]   sum;
  logic [W-1:0] idx;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    sum          = '0;
    idx          = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit so the wrap works for non-power-of-two N as well.
      sum = {1'b0, pointer} + W1'(k);
      if (sum >= W1'(N)) sum = sum - W1'(N);
      idx = sum[W-1:0];
      if (!any && req[idx]) begin
        any               = 1'b1;
        grant_idx         = idx;
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/debounce_event_scheduler.sv
// Debounces N_CH raw inputs with one shared tick prescaler and turns every
// accepted level change into an {channel, level} event, serialised through a
// round-robin arbiter onto a single valid/ready port.
// Ports:
//   clk        in   1       clock, rising edge
//   s_reset    in   1       synchronous active-high reset
//   in_raw     in   N_CH    asynchronous raw inputs
//   debounced  out  N_CH    accepted level per channel
//   evt_valid  out  1       event available
//   evt_ready  in   1       consumer takes the event when valid && ready
//   evt_ch     out  CH_W    channel of the current event
//   evt_level  out  1       new level of that channel
//   evt_lost   out  N_CH    sticky: a pending event on the channel was overwritten
//   lost_clr   in   1       clears evt_lost
module debounce_event_scheduler
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 10000,
  parameter int STABLE_TICKS = 10
) (
  input  logic                    clk,
  input  logic                    s_reset,
  input  logic [N_CH-1:0]         in_raw,
  output logic [N_CH-1:0]         debounced,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  output logic                    evt_level,
  output logic [N_CH-1:0]         evt_lost,
  input  logic                    lost_clr
);
  localparam int CH_W = idx_width(N_CH);
  localparam int CW   = cnt_width(STABLE_TICKS);
  localparam int PW   = idx_width(TICK_DIV);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            level;
  } evt_t;

  logic [N_CH-1:0] s1_reg, s2_reg, s3_reg;
  logic [PW-1:0]   presc_reg;
  logic [CW-1:0]   cnt_reg [N_CH];
  logic [N_CH-1:0] deb_reg, pend_reg, plev_reg, lost_reg;
  logic            valid_reg;
  evt_t            out_reg;
  logic [CH_W-1:0] ptr_reg;

  logic [N_CH-1:0] edge_det, accept, grant_clr, pend_next, lost_set, lost_next;
  logic [N_CH-1:0] gnt_oh;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt_any, tick, load;

  assign edge_det = s2_reg ^ s3_reg;
  assign tick     = (presc_reg == PW'(TICK_DIV - 1));
  // The output register may take a new event when empty or being drained.
  assign load     = !valid_reg || evt_ready;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_accept
    assign accept[gi] = (cnt_reg[gi] == CW'(STABLE_TICKS)) && (s3_reg[gi] != deb_reg[gi]);
  end

  rr_arbiter #(.N(N_CH)) u_arb (
    .req          (pend_reg),
    .pointer      (ptr_reg),
    .grant_onehot (gnt_oh),
    .grant_idx    (gnt_idx),
    .any          (gnt_any)
  );

  // A fresh accept beats a same-cycle grant clear; that case re-pends the
  // channel and is not an overwrite, since the old event was delivered.
  assign grant_clr = (load && gnt_any) ? gnt_oh : '0;
  assign pend_next = accept | (pend_reg & ~grant_clr);
  assign lost_set  = accept & pend_reg & ~grant_clr;
  assign lost_next = lost_set | (lost_clr ? '0 : lost_reg);

  always_ff @(posedge clk) begin
    if (s_reset) begin
      s1_reg    <= '0;
      s2_reg    <= '0;
      s3_reg    <= '0;
      presc_reg <= '0;
      for (int i = 0; i < N_CH; i++) cnt_reg[i] <= '0;
      deb_reg   <= '0;
      pend_reg  <= '0;
      plev_reg  <= '0;
      lost_reg  <= '0;
      valid_reg <= 1'b0;
      out_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      s1_reg <= in_raw;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;

      // Free-running; input edges never realign it.
      presc_reg <= tick ? '0 : presc_reg + PW'(1);

      for (int i = 0; i < N_CH; i++) begin
        if (edge_det[i])
          cnt_reg[i] <= '0;
        else if (tick && (cnt_reg[i] < CW'(STABLE_TICKS)))
          cnt_reg[i] <= cnt_reg[i] + CW'(1);
        if (accept[i]) begin
          deb_reg[i]  <= s3_reg[i];
          plev_reg[i] <= s3_reg[i];
        end
      end

      pend_reg <= pend_next;
      lost_reg <= lost_next;

      if (load) begin
        if (gnt_any) begin
          valid_reg     <= 1'b1;
          out_reg.ch    <= gnt_idx;
          out_reg.level <= plev_reg[gnt_idx];
          ptr_reg       <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
        end else begin
          valid_reg <= 1'b0;
        end
      end
    end
  end

  assign debounced = deb_reg;
  assign evt_valid = valid_reg;
  assign evt_ch    = out_reg.ch;
  assign evt_level = out_reg.level;
  assign evt_lost  = lost_reg;

endmodule

// File: tb/tb_debounce_event_scheduler.sv
// Directed scenarios plus a randomized phase for debounce_event_scheduler
// (N_CH=4, TICK_DIV=4, STABLE_TICKS=3). The random phase predicts events at
// the level of raw-input segments: a level held for >= 20 cycles must be
// accepted, one held for <= 8 cycles (at most 2 ticks) never can be.
module tb_debounce_event_scheduler;
  localparam int N_CH = 4, TICK_DIV = 4, STABLE_TICKS = 3;

  logic       clk = 1'b0;
  logic       s_reset = 1'b1;
  logic       evt_ready = 1'b0;
  logic       lost_clr = 1'b0;
  logic [3:0] in_raw = '0;
  logic [3:0] debounced, evt_lost;
  logic       evt_valid, evt_level;
  logic [1:0] evt_ch;

  always #5 clk = ~clk;

  debounce_event_scheduler #(
    .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk(clk), .s_reset(s_reset), .in_raw(in_raw), .debounced(debounced),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_level(evt_level), .evt_lost(evt_lost), .lost_clr(lost_clr)
  );

  typedef struct packed {logic [1:0] ch; logic level;} ev_t;
  ev_t mon_q[$];
  ev_t exp_q[$];
  logic obs_l[$];
  logic exp_l[$];
  int valid_cycles = 0;
  int n_checks = 0, n_fail = 0;
  int base, vbase, k;
  int rem [4];
  logic [3:0] lvl, dm;

  // Handshake monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!s_reset) begin
      if (evt_valid) valid_cycles++;
      if (evt_valid && evt_ready) begin
        mon_q.push_back('{ch: evt_ch, level: evt_level});
        $display("evt #%0d ch=%0d level=%0d t=%0t", mon_q.size() - 1, evt_ch, evt_level, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input string tag, input int idx, input int ch, input int lv);
    if (idx < mon_q.size()) begin
      chk({tag, ".ch"}, 32'(mon_q[idx].ch), 32'(ch));
      chk({tag, ".lvl"}, 32'(mon_q[idx].level), 32'(lv));
    end else begin
      chk({tag, ".present"}, 32'(mon_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && !evt_valid; i++) step();
    chk(tag, 32'(evt_valid), 32'd1);
  endtask

  initial begin
    // 1: reset held 3 cycles
    repeat (3) step();
    chk("rst.debounced", 32'(debounced), 32'd0);
    chk("rst.valid", 32'(evt_valid), 32'd0);
    chk("rst.lost", 32'(evt_lost), 32'd0);
    chk("rst.ch", 32'(evt_ch), 32'd0);
    s_reset = 1'b0;
    evt_ready = 1'b1;
    repeat (3) step();

    // 2: clean press on ch1; 3 sync stages + 3 ticks + accept -> 13..16 steps
    base = mon_q.size();
    vbase = valid_cycles;
    in_raw[1] = 1'b1;
    for (k = 1; k <= 30; k++) begin
      step();
      if (debounced[1]) break;
    end
    chk("press.deb_early", 32'(k >= 10), 32'd1);
    chk("press.deb_late", 32'(k <= 18), 32'd1);
    repeat (5) step();
    chk("press.count", 32'(mon_q.size() - base), 32'd1);
    expect_evt("press.e0", base, 1, 1);
    chk("press.valid_cycles", 32'(valid_cycles - vbase), 32'd1);

    // 3: bounce on ch0, 5-cycle segments never reach 3 ticks
    base = mon_q.size();
    for (int t = 0; t < 8; t++) begin
      in_raw[0] = ~in_raw[0];
      repeat (5) step();
    end
    chk("bounce.none", 32'(mon_q.size() - base), 32'd0);
    in_raw[0] = 1'b1;
    repeat (30) step();
    chk("bounce.count", 32'(mon_q.size() - base), 32'd1);
    expect_evt("bounce.e0", base, 0, 1);
    chk("bounce.deb", 32'(debounced), 32'b0011);

    // Prep: a ch3 event leaves the round-robin pointer at 0
    base = mon_q.size();
    in_raw[3] = 1'b1;
    repeat (25) step();
    expect_evt("prep.e0", base, 3, 1);

    // 4: ch0, ch2, ch3 accept in the same cycle while stalled
    base = mon_q.size();
    evt_ready = 1'b0;
    in_raw = 4'b0110;
    wait_valid("simul.valid", 30);
    for (int t = 0; t < 10; t++) begin
      step();
      chk("simul.stall_valid", 32'(evt_valid), 32'd1);
      chk("simul.stall_ch", 32'(evt_ch), 32'd0);
      chk("simul.stall_lvl", 32'(evt_level), 32'd0);
    end
    evt_ready = 1'b1;
    repeat (5) step();
    chk("simul.count", 32'(mon_q.size() - base), 32'd3);
    expect_evt("simul.e0", base, 0, 0);
    expect_evt("simul.e1", base + 1, 2, 1);
    expect_evt("simul.e2", base + 2, 3, 0);

    // Pointer is back at 0: simultaneous ch0/ch1 come out ch0 first
    base = mon_q.size();
    in_raw = 4'b0101;
    repeat (25) step();
    chk("rr.count", 32'(mon_q.size() - base), 32'd2);
    expect_evt("rr.e0", base, 0, 1);
    expect_evt("rr.e1", base + 1, 1, 0);

    // 5: overwrite of a pending ch1 event while the port is stalled on ch2
    base = mon_q.size();
    evt_ready = 1'b0;
    in_raw = 4'b0001;
    repeat (25) step();
    in_raw = 4'b0011;
    repeat (25) step();
    chk("ovw.no_lost_yet", 32'(evt_lost), 32'd0);
    in_raw = 4'b0001;
    repeat (25) step();
    chk("ovw.lost", 32'(evt_lost), 32'b0010);
    chk("ovw.stall_ch", 32'(evt_ch), 32'd2);
    evt_ready = 1'b1;
    repeat (5) step();
    chk("ovw.count", 32'(mon_q.size() - base), 32'd2);
    expect_evt("ovw.e0", base, 2, 0);
    expect_evt("ovw.e1", base + 1, 1, 0);
    chk("ovw.lost_sticky", 32'(evt_lost), 32'b0010);
    lost_clr = 1'b1;
    step();
    lost_clr = 1'b0;
    chk("ovw.lost_clr", 32'(evt_lost), 32'd0);

    // 6: reset while one event is held and two are pending
    evt_ready = 1'b0;
    in_raw = 4'b1100;
    repeat (25) step();
    chk("midrst.valid_before", 32'(evt_valid), 32'd1);
    s_reset = 1'b1;
    in_raw = '0;
    step();
    chk("midrst.valid", 32'(evt_valid), 32'd0);
    chk("midrst.deb", 32'(debounced), 32'd0);
    s_reset = 1'b0;
    evt_ready = 1'b1;
    base = mon_q.size();
    repeat (40) step();
    chk("midrst.no_stale", 32'(mon_q.size() - base), 32'd0);
    chk("midrst.valid_after", 32'(evt_valid), 32'd0);

    // Randomized: independent per-channel segments, short glitches or long holds
    base = mon_q.size();
    lvl = '0;
    dm = '0;
    for (int c = 0; c < 4; c++) rem[c] = int'($urandom_range(1, 8));
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < 4; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = ~lvl[c];
          if ($urandom_range(0, 1) == 1) begin
            rem[c] = int'($urandom_range(20, 40));
            if (lvl[c] != dm[c]) begin
              exp_q.push_back('{ch: 2'(c), level: lvl[c]});
              dm[c] = lvl[c];
            end
          end else begin
            rem[c] = int'($urandom_range(1, 8));
          end
        end
        rem[c]--;
      end
      in_raw = lvl;
      step();
    end
    // Inputs now freeze, so every channel's current level will settle.
    for (int c = 0; c < 4; c++)
      if (lvl[c] != dm[c]) exp_q.push_back('{ch: 2'(c), level: lvl[c]});
    repeat (60) step();
    for (int c = 0; c < 4; c++) begin
      obs_l.delete();
      exp_l.delete();
      for (int i = base; i < mon_q.size(); i++)
        if (int'(mon_q[i].ch) == c) obs_l.push_back(mon_q[i].level);
      for (int i = 0; i < exp_q.size(); i++)
        if (int'(exp_q[i].ch) == c) exp_l.push_back(exp_q[i].level);
      chk($sformatf("rand.ch%0d.count", c), 32'(obs_l.size()), 32'(exp_l.size()));
      for (int i = 0; i < obs_l.size() && i < exp_l.size(); i++)
        chk($sformatf("rand.ch%0d.e%0d", c, i), 32'(obs_l[i]), 32'(exp_l[i]));
    end
    chk("rand.deb", 32'(debounced), 32'(lvl));
    chk("rand.lost", 32'(evt_lost), 32'd0);
    chk("rand.idle", 32'(evt_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
